// File: rtl/rv_pkg.sv
// Shared RV32I encodings used by the MEM/WB stage: load/store sizes,
// writeback source select and the memrw store encoding.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    localparam logic MEMRW_STORE = 1'b1;

endpackage

// File: rtl/data_memory.sv
// Byte-lane data memory: four independent 8-bit lanes with per-lane write
// enables and an asynchronous word read. Contents are never reset.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_q [DEPTH_WORDS];

        // Lane write on the rising edge when the store targets this lane
        always_ff @(posedge clk) begin
            if (we && be[g]) begin
                lane_q[addr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = lane_q[addr];
    end

endmodule

// File: rtl/memory_writeback.sv
// MEM stage plus MEM/WB register and writeback select of the 5-stage RV32I
// core. Stores and loads go to the internal byte-lane data memory; the
// MEM/WB registers feed resultW to the register file and EX forwarding.
module memory_writeback
    import rv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regwriteM,
    input  logic        memrwM,
    input  logic [1:0]  wbselM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUresM,
    input  logic [31:0] data_writeM,
    input  logic [31:0] pc4M,
    output logic        misalignM,
    output logic        regwriteW,
    output logic [4:0]  rdW,
    output logic [31:0] resultW
);

    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          bad_access;
    logic          mem_access;
    logic          store_en;
    logic [3:0]    byte_en;
    logic [31:0]   store_data;
    logic [31:0]   mem_word;
    logic [31:0]   byte_lane;
    logic [31:0]   half_lane;
    logic [31:0]   load_data;

    logic [1:0]    wbselW;
    logic [31:0]   ALUresW;
    logic [31:0]   readdataW;
    logic [31:0]   pc4W;

    // Upper address bits are dropped, so accesses wrap modulo the memory size
    assign word_idx = ALUresM[AW+1:2];
    assign offset   = ALUresM[1:0];

    // Alignment / legality check, only meaningful when memory is touched
    always_comb begin
        bad_access = 1'b0;
        case (funct3M)
            F3_B, F3_BU: bad_access = 1'b0;
            F3_H, F3_HU: bad_access = offset[0];
            F3_W:        bad_access = (offset != 2'b00);
            default:     bad_access = 1'b1;
        endcase
        mem_access = (memrwM == MEMRW_STORE) || (wbselM == WB_MEM);
        misalignM  = mem_access && bad_access;
    end

    // Store lane steering: replicate the data and pick lanes by size/offset
    always_comb begin
        byte_en    = 4'b0000;
        store_data = data_writeM;
        case (funct3M[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << offset;
                store_data = {4{data_writeM[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << offset;
                store_data = {2{data_writeM[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    // A store coinciding with active reset, or a bad store, is dropped
    assign store_en = (memrwM == MEMRW_STORE) && !misalignM && rst_n;

    data_memory #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_data_memory (
        .clk  (clk),
        .we   (store_en),
        .be   (byte_en),
        .addr (word_idx),
        .wdata(store_data),
        .rdata(mem_word)
    );

    assign byte_lane = mem_word >> {offset, 3'b000};
    assign half_lane = mem_word >> {offset[1], 4'b0000};

    // Load lane extraction and sign/zero extension; bad loads read as zero
    always_comb begin
        load_data = 32'd0;
        if (!misalignM) begin
            case (funct3M)
                F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
                F3_BU:   load_data = {24'd0, byte_lane[7:0]};
                F3_H:    load_data = {{16{half_lane[15]}}, half_lane[15:0]};
                F3_HU:   load_data = {16'd0, half_lane[15:0]};
                F3_W:    load_data = mem_word;
                default: load_data = 32'd0;
            endcase
        end
    end

    // MEM/WB boundary: loads every cycle, bad loads lose their register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwriteW <= 1'b0;
            rdW       <= 5'd0;
            wbselW    <= 2'b00;
            ALUresW   <= 32'd0;
            readdataW <= 32'd0;
            pc4W      <= 32'd0;
        end else begin
            regwriteW <= regwriteM && !(misalignM && (wbselM == WB_MEM));
            rdW       <= rdM;
            wbselW    <= wbselM;
            ALUresW   <= ALUresM;
            readdataW <= load_data;
            pc4W      <= pc4M;
        end
    end

    // Writeback source select
    always_comb begin
        resultW = 32'd0;
        case (wbselW)
            WB_MEM:  resultW = readdataW;
            WB_ALU:  resultW = ALUresW;
            WB_PC4:  resultW = pc4W;
            default: resultW = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_memory_writeback.sv
// Scoreboard bench for memory_writeback: a byte-array reference model
// predicts misalignM and the MEM/WB outputs for every issued instruction.
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwriteM;
    logic        memrwM;
    logic [1:0]  wbselM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] ALUresM;
    logic [31:0] data_writeM;
    logic [31:0] pc4M;
    logic        misalignM;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;

    memory_writeback #(.DEPTH_WORDS(256), .AW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regwriteM  (regwriteM),
        .memrwM     (memrwM),
        .wbselM     (wbselM),
        .funct3M    (funct3M),
        .rdM        (rdM),
        .ALUresM    (ALUresM),
        .data_writeM(data_writeM),
        .pc4M       (pc4M),
        .misalignM  (misalignM),
        .regwriteW  (regwriteW),
        .rdW        (rdW),
        .resultW    (resultW)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   tag;
        logic mis;
    } mis_t;

    typedef struct {
        int          tag;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } wb_t;

    mis_t q_mis[$];
    wb_t  q_wb[$];

    logic [7:0] ref_mem [1024];
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: misalignM against the instruction presented this cycle,
    // registered outputs against the instruction presented one cycle ago
    mis_t mon_m;
    wb_t  mon_w;
    always @(negedge clk) begin
        if (q_mis.size() > 0 && q_mis[0].tag == cyc) begin
            mon_m = q_mis.pop_front();
            check("misalignM", {31'd0, misalignM}, {31'd0, mon_m.mis});
        end
        if (q_wb.size() > 0 && q_wb[0].tag == cyc - 1) begin
            mon_w = q_wb.pop_front();
            check("regwriteW", {31'd0, regwriteW}, {31'd0, mon_w.rw});
            check("rdW", {27'd0, rdW}, {27'd0, mon_w.rd});
            check("resultW", resultW, mon_w.res);
        end
    end

    // Drive one instruction, predict its outcome and update the memory model
    task automatic issue(input logic rw, input logic mrw, input logic [1:0] wb,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4);
        int          a;
        logic [1:0]  off;
        logic        illegal, active, mis;
        logic [31:0] ld, res;
        int          nbytes;
        mis_t        m;
        wb_t         w;
        @(posedge clk);
        #1;
        regwriteM   = rw;
        memrwM      = mrw;
        wbselM      = wb;
        funct3M     = f3;
        rdM         = rd;
        ALUresM     = alu;
        data_writeM = wd;
        pc4M        = pc4;

        a       = int'(alu[9:0]);
        off     = alu[1:0];
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        active  = mrw || (wb == 2'b00);
        mis     = active && (illegal ||
                             (((f3 == 3'b001) || (f3 == 3'b101)) && off[0]) ||
                             ((f3 == 3'b010) && (off != 2'b00)));
        ld = 32'd0;
        if (!mis) begin
            case (f3)
                3'b000: ld = {{24{ref_mem[a][7]}}, ref_mem[a]};
                3'b100: ld = {24'd0, ref_mem[a]};
                3'b001: ld = {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
                3'b101: ld = {16'd0, ref_mem[a+1], ref_mem[a]};
                3'b010: ld = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
                default: ld = 32'd0;
            endcase
        end
        case (wb)
            2'b00:   res = ld;
            2'b01:   res = alu;
            2'b10:   res = pc4;
            default: res = 32'd0;
        endcase
        m.tag = cyc;
        m.mis = mis;
        q_mis.push_back(m);
        w.tag = cyc;
        w.rw  = rw && !(mis && (wb == 2'b00));
        w.rd  = rd;
        w.res = res;
        q_wb.push_back(w);

        if (mrw && !mis) begin
            nbytes = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
        end
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(1'b0, 1'b1, 2'b11, f3, 5'd0, addr, wd, 32'd0);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        issue(1'b1, 1'b0, 2'b00, f3, rd, addr, 32'd0, 32'd0);
    endtask

    initial begin
        logic [2:0] st_f3 [6];
        st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        rst_n = 1'b0;
        regwriteM = 1'b0; memrwM = 1'b0; wbselM = 2'b00; funct3M = 3'b000;
        rdM = 5'd0; ALUresM = 32'd0; data_writeM = 32'd0; pc4M = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_regwriteW", {31'd0, regwriteW}, 32'd0);
        check("reset_rdW", {27'd0, rdW}, 32'd0);
        check("reset_resultW", resultW, 32'd0);
        rst_n = 1'b1;

        // Give every word a known value so any later load is predictable
        for (int w = 0; w < 256; w++) store(3'b010, w * 4, $urandom);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset mid-cycle with a register write pending
        regwriteM = 1'b1; memrwM = 1'b0; wbselM = 2'b01; funct3M = 3'b000;
        rdM = 5'd7; ALUresM = 32'h55; pc4M = 32'h8;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_regwriteW", {31'd0, regwriteW}, 32'd0);
        check("async_rst_rdW", {27'd0, rdW}, 32'd0);
        check("async_rst_resultW", resultW, 32'd0);
        // A store presented while reset is held must be dropped
        memrwM = 1'b1; funct3M = 3'b010; ALUresM = 32'h40; data_writeM = 32'hBADBAD00;
        @(posedge clk);
        #1;
        check("held_rst_resultW", resultW, 32'd0);
        check("held_rst_regwriteW", {31'd0, regwriteW}, 32'd0);
        memrwM = 1'b0; regwriteM = 1'b1; rdM = 5'd9; wbselM = 2'b01; ALUresM = 32'h77;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_regwriteW", {31'd0, regwriteW}, 32'd1);
        check("post_rst_rdW", {27'd0, rdW}, 32'd9);
        check("post_rst_resultW", resultW, 32'h77);

        // Directed cases
        load(3'b010, 32'h40, 5'd3);
        store(3'b010, 32'h10, 32'hDEADBEEF);
        load(3'b010, 32'h10, 5'd5);
        store(3'b010, 32'h20, 32'h0);
        store(3'b000, 32'h21, 32'h80);
        load(3'b000, 32'h21, 5'd1);
        load(3'b100, 32'h21, 5'd2);
        load(3'b010, 32'h20, 5'd3);
        store(3'b001, 32'h22, 32'hA5A5);
        load(3'b101, 32'h22, 5'd4);
        load(3'b001, 32'h22, 5'd4);
        store(3'b010, 32'h31, 32'hCAFEF00D);
        load(3'b010, 32'h30, 5'd6);
        load(3'b001, 32'h33, 5'd8);
        load(3'b011, 32'h34, 5'd8);
        issue(1'b1, 1'b0, 2'b01, 3'b011, 5'd10, 32'h1234, 32'd0, 32'h0);
        issue(1'b1, 1'b0, 2'b10, 3'b001, 5'd11, 32'h3, 32'd0, 32'h104);
        issue(1'b1, 1'b0, 2'b11, 3'b000, 5'd12, 32'h99, 32'd0, 32'h200);
        issue(1'b1, 1'b0, 2'b01, 3'b000, 5'd0, 32'h5A5A, 32'd0, 32'h0);
        store(3'b010, 32'h400, 32'h11111111);
        load(3'b010, 32'h000, 5'd13);

        // Randomized mix of stores, loads and non-memory writebacks
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0: store(st_f3[$urandom_range(0, 5)], $urandom, $urandom);
                1: load(3'($urandom_range(0, 7)), $urandom, 5'($urandom));
                default: issue(1'($urandom), 1'b0, 2'($urandom_range(1, 3)),
                               3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            endcase
        end
        issue(1'b0, 1'b0, 2'b11, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);

        // Bounded drain of the scoreboard
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (q_mis.size() != 0 || q_wb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d misalign and %0d writeback entries left, expected 0",
                     q_mis.size(), q_wb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_writeback.md
Name: memory_writeback

Overview:
- Pipeline MEM stage plus MEM/WB register and writeback select for the 5-stage RV32I core.
- Consumes the EX/MEM register outputs and performs loads and stores against an internal byte-lane data memory.
- Registers the results into the MEM/WB boundary and drives resultW back to register-file write and EX forwarding.
- memrw encoding: 1 = store (write), 0 = no write / load.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data memory; power of two.
- AW, 8, word-index width; must equal log2(DEPTH_WORDS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- regwriteM  in  1  register write enable from EX/MEM.
- memrwM  in  1  1 = store this cycle.
- wbselM  in  2  writeback source: 00 memory, 01 ALU, 10 pc+4, 11 zero.
- funct3M  in  3  load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdM  in  5  destination register.
- ALUresM  in  32  effective address / ALU result.
- data_writeM  in  32  store data, right-aligned.
- pc4M  in  32  pc+4 of the instruction.
- misalignM  out  1  combinational: current access is misaligned or has an illegal funct3.
- regwriteW  out  1  registered write enable.
- rdW  out  5  registered destination.
- resultW  out  32  combinational writeback value from MEM/WB registers.

Behaviour:
- Address decode: word index = ALUresM[AW+1:2]; byte offset = ALUresM[1:0]; upper address bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- misalignM asserts when any of these hold, and only while memrwM=1 or wbselM=00:
  - halfword with offset[0]=1;
  - word with offset!=0;
  - funct3 in {011, 110, 111}.
- Store (memrwM=1, misalignM=0): write at the rising edge using byte enables.
  - SB: lane = offset, data_writeM[7:0].
  - SH: lanes offset and offset+1, data_writeM[15:0].
  - SW: all lanes.
  - A misaligned or illegal store writes nothing.
- Load path: combinational array read, lane-extracted and sign/zero extended per funct3.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - A misaligned or illegal load yields 0.
- Memory behaviour: the array is not reset and its contents are undefined until written. A load issued in the cycle after a store to the same word sees the new data.
- MEM/WB registers: regwriteW, rdW, wbselW, ALUresW, readdataW, pc4W all load every clock. Latency from MEM inputs to resultW is 1 cycle.
- A misaligned or illegal load forces the registered regwriteW to 0 (no architectural write).
- resultW selects by wbselW:
  - 00 -> readdataW
  - 01 -> ALUresW
  - 10 -> pc4W
  - 11 -> 0
- Writes to rd=0 pass through unchanged; the register file ignores x0.
- Reset (async, any time, including mid-store): all MEM/WB registers clear to 0, so regwriteW=0, rdW=0, resultW=0.
  - A store whose edge coincides with active reset is dropped.
  - Memory contents are retained across reset.
- No stall or flush inputs: the stage advances every cycle. Bubbles arrive as regwriteM=0 and memrwM=0.

Decomposition:
- Shared package rv_pkg holds:
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - WB_MEM, WB_ALU, WB_PC4 encodings;
  - the memrw store encoding.
- One sub-module, data_memory:
  - parameterised DEPTH_WORDS/AW;
  - 4 byte lanes, per-lane write enable;
  - asynchronous word read.
- Lane steering, extension, misalignment detection, pipeline registers and the result mux stay in memory_writeback.

Test Plan:
- Reset: rst_n=0 mid-cycle with regwriteM=1 held -> regwriteW=0, rdW=0, resultW=0 immediately. After release, the first edge latches the inputs.
- SW/LW: store 0xDEADBEEF at address 0x10; next cycle LW 0x10, wbsel=00, rd=5 -> one cycle later resultW=0xDEADBEEF, rdW=5, regwriteW=1.
- Byte/half lanes: SB 0x80 at 0x21 over word 0x00000000, then:
  - LB 0x21 -> 0xFFFFFF80;
  - LBU 0x21 -> 0x00000080;
  - LW 0x20 -> 0x00008000;
  - SH 0xA5A5 at 0x22, then LHU 0x22 -> 0x0000A5A5.
- Misalignment: SW at 0x31 -> misalignM=1 and memory unchanged (LW 0x30 returns prior value); LH 0x33 -> misalignM=1, resultW=0, regwriteW=0.
- Writeback select: wbsel=01, ALUres=0x1234 -> resultW=0x1234; wbsel=10, pc4=0x104 -> 0x104; wbsel=11 -> 0.
- Wrap-around: with DEPTH_WORDS=256, SW 0x11111111 at 0x400, then LW 0x000 -> 0x11111111.
